// File: rtl/fb_write_queue_pkg.sv
// Shared framebuffer write types and default widths.
// Used by fb_write_queue (configurable with FB_WQ_COALESCE_EN) and the framebuffer stage.
package fb_pkg;

    localparam int FB_ADDR_WIDTH = 24;
    localparam int FB_DATA_WIDTH = 32;

    // One queued pixel write: destination address plus colour data.
    typedef struct packed {
        logic [FB_ADDR_WIDTH-1:0] addr;
        logic [FB_DATA_WIDTH-1:0] data;
    } fb_wr_t;

endpackage

// File: rtl/fb_write_queue_if.sv
// Memory-side valid/ready write bus of fb_write_queue.
// The queue is the master; the memory interconnect is the slave.
interface fb_write_queue_if #(
    parameter int ADDR_WIDTH = fb_pkg::FB_ADDR_WIDTH,
    parameter int DATA_WIDTH = fb_pkg::FB_DATA_WIDTH
) ();
    import fb_pkg::*;

    logic                  o_mem_valid;
    logic                  i_mem_ready;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wdata;

    modport master (
        output o_mem_valid,
        output o_mem_addr,
        output o_mem_wdata,
        input  i_mem_ready
    );

    modport slave (
        input  o_mem_valid,
        input  o_mem_addr,
        input  o_mem_wdata,
        output i_mem_ready
    );

endinterface

// File: rtl/fb_write_queue_mem.sv
// Entry storage for fb_write_queue: DEPTH x fb_wr_t register array with
// one synchronous write port and one asynchronous read port at the head.
module fb_wq_mem
    import fb_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] wr_idx,
    input  fb_wr_t           wr_entry,
    input  logic [PTR_W-1:0] rd_idx,
    output fb_wr_t           rd_entry
);

    fb_wr_t mem [DEPTH];

    // Entries need no reset: the occupancy counter decides what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/fb_write_queue.sv
// Framebuffer write queue: buffers un-backpressured pixel writes and issues
// them in order over a valid/ready bus, flagging dropped writes as overflow.
// Optional feature macro FB_WQ_COALESCE_EN: a write to the same address as the
// youngest queued entry (when that entry is not the head) overwrites its data.
// ADDR_WIDTH/DATA_WIDTH must match the fb_pkg widths used by fb_wr_t.
module fb_write_queue
    import fb_pkg::*;
#(
    parameter  int ADDR_WIDTH         = FB_ADDR_WIDTH,
    parameter  int DATA_WIDTH         = FB_DATA_WIDTH,
    parameter  int DEPTH              = 16,
    parameter  int ALMOST_FULL_MARGIN = 2,
    localparam int PTR_W              = $clog2(DEPTH),
    localparam int LVL_W              = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_req,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_almost_full,
    fb_write_queue_if.master      mem_bus,
    output logic [LVL_W-1:0]      o_level,
    output logic                  o_overflow,
    output logic                  o_idle
);

    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] MARGIN_L = LVL_W'(ALMOST_FULL_MARGIN);

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_next;
    logic             overflow_q;
    logic             almost_full_q;
    logic             pop;
    logic             push;
    logic             drop;
    logic             coalesce;
    logic             mem_we;
    fb_wr_t           wr_entry;
    fb_wr_t           head_entry;

    assign pop = (level != '0) && mem_bus.i_mem_ready;

`ifdef FB_WQ_COALESCE_EN
    logic [ADDR_WIDTH-1:0] last_addr;

    // Remember the address of the youngest entry; it stays in the queue while level>=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr <= '0;
        end else if (push) begin
            last_addr <= i_wr_addr;
        end
    end

    // Merge only when the youngest entry is not the head, so the presented head never changes.
    assign coalesce = i_wr_req && (level >= LVL_W'(2)) && (i_wr_addr == last_addr);
`else
    assign coalesce = 1'b0;
`endif

    // A full queue still accepts a write when the head leaves in the same cycle.
    assign push = i_wr_req && !coalesce && ((level != DEPTH_L) || pop);
    assign drop = i_wr_req && !coalesce && (level == DEPTH_L) && !pop;

    // Pick the storage write: a fresh slot at the tail, or the youngest slot when merging.
    always_comb begin
        mem_we        = push || coalesce;
        wr_idx        = tail_ptr;
        wr_entry.addr = i_wr_addr;
        wr_entry.data = i_wr_data;
        if (coalesce) begin
            wr_idx = tail_ptr - PTR_W'(1);
        end
    end

    // Occupancy after this cycle's push and pop.
    always_comb begin
        level_next = level + LVL_W'(push) - LVL_W'(pop);
    end

    // Pointers, occupancy and flags; reset throws away all queued entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr      <= '0;
            tail_ptr      <= '0;
            level         <= '0;
            overflow_q    <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            level         <= level_next;
            almost_full_q <= (DEPTH_L - level_next) <= MARGIN_L;
        end
    end

    fb_wq_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk      (clk),
        .we       (mem_we),
        .wr_idx   (wr_idx),
        .wr_entry (wr_entry),
        .rd_idx   (head_ptr),
        .rd_entry (head_entry)
    );

    // Head is presented whenever anything is queued; address/data read as zero when empty.
    always_comb begin
        mem_bus.o_mem_valid = (level != '0);
        mem_bus.o_mem_addr  = '0;
        mem_bus.o_mem_wdata = '0;
        if (level != '0) begin
            mem_bus.o_mem_addr  = head_entry.addr;
            mem_bus.o_mem_wdata = head_entry.data;
        end
    end

    assign o_level       = level;
    assign o_overflow    = overflow_q;
    assign o_almost_full = almost_full_q;
    assign o_idle        = (level == '0) && !i_wr_req;

endmodule
